// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: does the initial AddRoundKey itself, then drives one
// shared registered round stage NR times, fetching each round key from an external key store.
module aes_round_sequencer #(
  parameter int unsigned NR        = 10,
  parameter int unsigned STAGE_LAT = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_data_i,
  output logic         stage_start_o,
  output logic         stage_last_o,
  output logic [127:0] stage_in_o,
  output logic [127:0] stage_key_o,
  input  logic [127:0] stage_out_i
);

  localparam logic [3:0] NrVal    = 4'(NR);
  localparam logic [2:0] WaitLast = 3'(STAGE_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e       state_q;
  logic [127:0] state_reg_q;
  logic [127:0] out_data_q;
  logic [3:0]   round_q;
  logic [3:0]   rk_idx_q;
  logic [2:0]   wait_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         stage_start_q;
  logic         stage_last_q;

  // All handshake and stage controls are registered alongside the state so they change
  // exactly on the state transition edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      state_reg_q   <= '0;
      out_data_q    <= '0;
      round_q       <= '0;
      rk_idx_q      <= '0;
      wait_q        <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      stage_start_q <= 1'b0;
      stage_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            state_reg_q   <= in_data_i ^ rk_data_i;
            round_q       <= 4'd1;
            rk_idx_q      <= 4'd1;
            wait_q        <= '0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b1;
            stage_start_q <= 1'b1;
            stage_last_q  <= (NrVal == 4'd1);
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          wait_q <= wait_q + 3'd1;
          if (wait_q == WaitLast) begin
            stage_start_q <= 1'b0;
            state_q       <= StCapture;
          end
        end
        StCapture: begin
          state_reg_q <= stage_out_i;
          if (round_q == NrVal) begin
            out_data_q   <= stage_out_i;
            out_valid_q  <= 1'b1;
            stage_last_q <= 1'b0;
            state_q      <= StDone;
          end else begin
            round_q       <= round_q + 4'd1;
            rk_idx_q      <= round_q + 4'd1;
            wait_q        <= '0;
            stage_start_q <= 1'b1;
            stage_last_q  <= ((round_q + 4'd1) == NrVal);
            state_q       <= StIssue;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            rk_idx_q    <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign busy_o        = busy_q;
  assign rk_idx_o      = rk_idx_q;
  assign stage_start_o = stage_start_q;
  assign stage_last_o  = stage_last_q;
  assign stage_in_o    = state_reg_q;
  assign stage_key_o   = rk_data_i;

endmodule
